bus_toggle_monitor: RTL

- Switching-activity monitor placed directly downstream of the bus-invert encoder.
- Samples the raw 8-bit data bus and the 9-bit encoded bus (data plus invert line) every enabled cycle.
- Counts bit transitions on each bus over a fixed window of samples and reports both totals with a one-cycle valid pulse.
- Gives an on-chip figure of merit for encoder power savings, cross-checked against the power report.

---
 rtl/bus_toggle_monitor_if.sv | 34 +++
 rtl/bus_toggle_monitor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bus_toggle_monitor_if.sv
`timescale 1ns/1ps
// Port bundle for bus_toggle_monitor: sampled buses and controls in, window results out.
// The slave modport is the monitor side; the master modport is the stimulus side.
interface bus_toggle_monitor_if #(
  parameter int RAW_W = 8,
  parameter int ENC_W = 9,
  parameter int CNT_W = 16
) ();
  localparam int PEAK_W = $clog2(ENC_W + 1);

  logic              en;
  logic              clr;
  logic [RAW_W-1:0]  raw_in;
  logic [ENC_W-1:0]  enc_in;
  logic [CNT_W-1:0]  raw_total;
  logic [CNT_W-1:0]  enc_total;
  logic              win_valid;
  logic              enc_better;
  logic              sat;
  logic [PEAK_W-1:0] enc_peak;
  logic              state_dbg;

  // Handshake: win_valid is a one-cycle pulse with no ready or backpressure. raw_total,
  // enc_total, enc_better and enc_peak are valid from that cycle and hold until the next pulse.
  modport master (
    output en, clr, raw_in, enc_in,
    input  raw_total, enc_total, win_valid, enc_better, sat, enc_peak, state_dbg
  );

  modport slave (
    input  en, clr, raw_in, enc_in,
    output raw_total, enc_total, win_valid, enc_better, sat, enc_peak, state_dbg
  );
endinterface

// File: rtl/bus_toggle_monitor.sv
`timescale 1ns/1ps
// Switching-activity monitor: counts raw vs bus-invert-encoded bit toggles per WINDOW samples.
// Build option PEAK_TRACK_EN adds tracking of the peak per-sample encoded toggle count (enc_peak).
module bus_toggle_monitor #(
  parameter int RAW_W  = 8,
  parameter int ENC_W  = 9,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 256
) (
  input  logic                  ck,
  input  logic                  rst,
  bus_toggle_monitor_if.slave   bus
);
  localparam int PEAK_W = $clog2(ENC_W + 1);
  localparam int SMP_W  = $clog2(WINDOW);
  localparam int SUM_W  = CNT_W + 1;
  localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] ACC_MAX  = '1;

  typedef enum logic {PRIME = 1'b0, ACCUM = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [RAW_W-1:0]   raw_prev_q, raw_prev_d;
  logic [ENC_W-1:0]   enc_prev_q, enc_prev_d;
  logic [CNT_W-1:0]   raw_acc_q, raw_acc_d;
  logic [CNT_W-1:0]   enc_acc_q, enc_acc_d;
  logic [SMP_W-1:0]   smp_q, smp_d;
  logic [CNT_W-1:0]   raw_total_q, raw_total_d;
  logic [CNT_W-1:0]   enc_total_q, enc_total_d;
  logic               win_valid_q, win_valid_d;
  logic               enc_better_q, enc_better_d;
  logic               sat_q, sat_d;

  logic [PEAK_W-1:0]  raw_cnt, enc_cnt;
  logic [SUM_W-1:0]   raw_sum, enc_sum;
  logic [CNT_W-1:0]   raw_next, enc_next;

  function automatic logic [PEAK_W-1:0] popcount(input logic [ENC_W-1:0] v);
    logic [PEAK_W-1:0] n;
    n = '0;
    for (int i = 0; i < ENC_W; i++) n = n + PEAK_W'(v[i]);
    return n;
  endfunction

  // Per-sample counts are zero-extended; the extra sum bit flags an overflow to clamp.
  assign raw_cnt  = popcount(ENC_W'(bus.raw_in ^ raw_prev_q));
  assign enc_cnt  = popcount(bus.enc_in ^ enc_prev_q);
  assign raw_sum  = {1'b0, raw_acc_q} + SUM_W'(raw_cnt);
  assign enc_sum  = {1'b0, enc_acc_q} + SUM_W'(enc_cnt);
  assign raw_next = raw_sum[CNT_W] ? ACC_MAX : raw_sum[CNT_W-1:0];
  assign enc_next = enc_sum[CNT_W] ? ACC_MAX : enc_sum[CNT_W-1:0];

`ifdef PEAK_TRACK_EN
  logic [PEAK_W-1:0] peak_q, peak_d;
  logic [PEAK_W-1:0] enc_peak_q, enc_peak_d;
  logic [PEAK_W-1:0] peak_next;
  assign peak_next = (enc_cnt > peak_q) ? enc_cnt : peak_q;
`endif

  always_comb begin
    state_d      = state_q;
    raw_prev_d   = raw_prev_q;
    enc_prev_d   = enc_prev_q;
    raw_acc_d    = raw_acc_q;
    enc_acc_d    = enc_acc_q;
    smp_d        = smp_q;
    raw_total_d  = raw_total_q;
    enc_total_d  = enc_total_q;
    enc_better_d = enc_better_q;
    sat_d        = sat_q;
    win_valid_d  = 1'b0;
`ifdef PEAK_TRACK_EN
    peak_d       = peak_q;
    enc_peak_d   = enc_peak_q;
`endif
    if (bus.clr) begin
      state_d      = PRIME;
      raw_prev_d   = '0;
      enc_prev_d   = '0;
      raw_acc_d    = '0;
      enc_acc_d    = '0;
      smp_d        = '0;
      raw_total_d  = '0;
      enc_total_d  = '0;
      enc_better_d = 1'b0;
      sat_d        = 1'b0;
`ifdef PEAK_TRACK_EN
      peak_d       = '0;
      enc_peak_d   = '0;
`endif
    end else if (bus.en) begin
      raw_prev_d = bus.raw_in;
      enc_prev_d = bus.enc_in;
      if (state_q == PRIME) begin
        state_d = ACCUM;
      end else begin
        sat_d = sat_q | raw_sum[CNT_W] | enc_sum[CNT_W];
        // Closing sample: totals include it, accumulators restart, prev keeps running.
        if (smp_q == LAST_SMP) begin
          raw_total_d  = raw_next;
          enc_total_d  = enc_next;
          enc_better_d = (enc_next < raw_next);
          win_valid_d  = 1'b1;
          raw_acc_d    = '0;
          enc_acc_d    = '0;
          smp_d        = '0;
`ifdef PEAK_TRACK_EN
          enc_peak_d   = peak_next;
          peak_d       = '0;
`endif
        end else begin
          raw_acc_d = raw_next;
          enc_acc_d = enc_next;
          smp_d     = smp_q + 1'b1;
`ifdef PEAK_TRACK_EN
          peak_d    = peak_next;
`endif
        end
      end
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q      <= PRIME;
      raw_prev_q   <= '0;
      enc_prev_q   <= '0;
      raw_acc_q    <= '0;
      enc_acc_q    <= '0;
      smp_q        <= '0;
      raw_total_q  <= '0;
      enc_total_q  <= '0;
      win_valid_q  <= 1'b0;
      enc_better_q <= 1'b0;
      sat_q        <= 1'b0;
`ifdef PEAK_TRACK_EN
      peak_q       <= '0;
      enc_peak_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      raw_prev_q   <= raw_prev_d;
      enc_prev_q   <= enc_prev_d;
      raw_acc_q    <= raw_acc_d;
      enc_acc_q    <= enc_acc_d;
      smp_q        <= smp_d;
      raw_total_q  <= raw_total_d;
      enc_total_q  <= enc_total_d;
      win_valid_q  <= win_valid_d;
      enc_better_q <= enc_better_d;
      sat_q        <= sat_d;
`ifdef PEAK_TRACK_EN
      peak_q       <= peak_d;
      enc_peak_q   <= enc_peak_d;
`endif
    end
  end

  assign bus.raw_total  = raw_total_q;
  assign bus.enc_total  = enc_total_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.enc_better = enc_better_q;
  assign bus.sat        = sat_q;
  assign bus.state_dbg  = state_q;
`ifdef PEAK_TRACK_EN
  assign bus.enc_peak   = enc_peak_q;
`else
  assign bus.enc_peak   = '0;
`endif
endmodule
